// File: rtl/ps2_line_buffer_if.sv
// Character stream from ps2_line_buffer to the Morse encoder.
// The buffer drives char_out/char_valid; the encoder answers with char_ready.
interface ps2_line_buffer_if;
  logic [5:0] char_out;
  logic       char_valid;
  logic       char_ready;

  modport master (
    output char_out,
    output char_valid,
    input  char_ready
  );

  modport slave (
    input  char_out,
    input  char_valid,
    output char_ready
  );
endinterface

// File: rtl/ps2_line_buffer.sv
// ps2_line_buffer: decodes PS/2 set-2 make codes into 6-bit character codes,
// keeps an editable line (Backspace/Esc) and streams it to the Morse
// encoder over a valid/ready handshake when Enter is pressed.
// Break (F0) and extended (E0) prefixed bytes are swallowed in both states.
// Optional build macro PS2_LINE_BUFFER_AUTO_FLUSH_EN: filling the last slot
// starts playback as if Enter had been pressed.
module ps2_line_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ps2_received_data,
  input  logic              ps2_received_data_strb,
  ps2_line_buffer_if.master char_if,
  output logic              busy,
  output logic [ADDR_W:0]   buffer_count,
  output logic              overflow
);

  typedef enum logic [2:0] {
    K_NONE  = 3'd0,
    K_CHAR  = 3'd1,
    K_ENTER = 3'd2,
    K_BKSP  = 3'd3,
    K_ESC   = 3'd4
  } kind_e;

  typedef enum logic {
    ST_COLLECT  = 1'b0,
    ST_PLAYBACK = 1'b1
  } state_e;

  localparam logic [ADDR_W:0]   ZERO_CNT = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ZERO_PTR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_PTR  = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Make code to {hit, character code}; hit=0 for non-character codes.
  function automatic logic [6:0] char_decode(input logic [7:0] code);
    logic [6:0] res;
    case (code)
      8'h29: res = {1'b1, 6'd0};
      8'h1C: res = {1'b1, 6'd1};   8'h32: res = {1'b1, 6'd2};
      8'h21: res = {1'b1, 6'd3};   8'h23: res = {1'b1, 6'd4};
      8'h24: res = {1'b1, 6'd5};   8'h2B: res = {1'b1, 6'd6};
      8'h34: res = {1'b1, 6'd7};   8'h33: res = {1'b1, 6'd8};
      8'h43: res = {1'b1, 6'd9};   8'h3B: res = {1'b1, 6'd10};
      8'h42: res = {1'b1, 6'd11};  8'h4B: res = {1'b1, 6'd12};
      8'h3A: res = {1'b1, 6'd13};  8'h31: res = {1'b1, 6'd14};
      8'h44: res = {1'b1, 6'd15};  8'h4D: res = {1'b1, 6'd16};
      8'h15: res = {1'b1, 6'd17};  8'h2D: res = {1'b1, 6'd18};
      8'h1B: res = {1'b1, 6'd19};  8'h2C: res = {1'b1, 6'd20};
      8'h3C: res = {1'b1, 6'd21};  8'h2A: res = {1'b1, 6'd22};
      8'h1D: res = {1'b1, 6'd23};  8'h22: res = {1'b1, 6'd24};
      8'h35: res = {1'b1, 6'd25};  8'h1A: res = {1'b1, 6'd26};
      8'h45: res = {1'b1, 6'd27};  8'h16: res = {1'b1, 6'd28};
      8'h1E: res = {1'b1, 6'd29};  8'h26: res = {1'b1, 6'd30};
      8'h25: res = {1'b1, 6'd31};  8'h2E: res = {1'b1, 6'd32};
      8'h36: res = {1'b1, 6'd33};  8'h3D: res = {1'b1, 6'd34};
      8'h3E: res = {1'b1, 6'd35};  8'h46: res = {1'b1, 6'd36};
      default: res = {1'b0, 6'd0};
    endcase
    return res;
  endfunction

  state_e            state_r;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              brk_r;
  logic              ext_r;
  logic [5:0]        char_out_r;
  logic              char_valid_r;
  logic              busy_r;
  logic              overflow_r;
  logic [5:0]        mem_r [DEPTH];

  kind_e             kind_s;
  logic [5:0]        char_s;
  logic [6:0]        decode_s;
  logic              full_s;
  logic              last_s;
  logic              xfer_s;
  logic              we_s;
  logic [ADDR_W-1:0] rd_next_s;
  logic [ADDR_W:0]   count_inc_s;
  logic [ADDR_W:0]   rd_pos_s;

  // Classify the strobed byte; prefixes and prefixed bytes yield no action.
  always_comb begin
    kind_s   = K_NONE;
    char_s   = 6'd0;
    decode_s = char_decode(ps2_received_data);
    if (!ps2_received_data_strb) begin
      kind_s = K_NONE;
    end else if ((ps2_received_data == 8'hE0) || (ps2_received_data == 8'hF0) ||
                 brk_r || ext_r) begin
      kind_s = K_NONE;
    end else if (decode_s[6]) begin
      kind_s = K_CHAR;
      char_s = decode_s[5:0];
    end else if (ps2_received_data == 8'h5A) begin
      kind_s = K_ENTER;
    end else if (ps2_received_data == 8'h66) begin
      kind_s = K_BKSP;
    end else if (ps2_received_data == 8'h76) begin
      kind_s = K_ESC;
    end else begin
      kind_s = K_NONE;
    end
  end

  // Buffer status and handshake helpers.
  always_comb begin
    full_s      = (count_r == FULL_CNT);
    count_inc_s = count_r + ONE_CNT;
    rd_next_s   = rd_ptr_r + ONE_PTR;
    rd_pos_s    = {1'b0, rd_ptr_r} + ONE_CNT;
    last_s      = (rd_pos_s >= count_r);
    xfer_s      = char_valid_r & char_if.char_ready;
    we_s        = (state_r == ST_COLLECT) && (kind_s == K_CHAR) && !full_s;
  end

  // Line storage; left unreset so it maps onto plain RAM, count gates reads.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[wr_ptr_r] <= char_s;
    end
  end

  // Main controller: prefix filter, line editing and playback handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_COLLECT;
      wr_ptr_r     <= ZERO_PTR;
      rd_ptr_r     <= ZERO_PTR;
      count_r      <= ZERO_CNT;
      brk_r        <= 1'b0;
      ext_r        <= 1'b0;
      char_out_r   <= 6'd0;
      char_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      overflow_r <= 1'b0;
      if (ps2_received_data_strb) begin
        if (ps2_received_data == 8'hE0) begin
          ext_r <= 1'b1;
        end else if (ps2_received_data == 8'hF0) begin
          brk_r <= 1'b1;
        end else begin
          brk_r <= 1'b0;
          ext_r <= 1'b0;
        end
      end
      case (state_r)
        ST_COLLECT: begin
          char_valid_r <= 1'b0;
          case (kind_s)
            K_CHAR: begin
              if (!full_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
                count_r  <= count_inc_s;
`ifdef PS2_LINE_BUFFER_AUTO_FLUSH_EN
                if (count_inc_s == FULL_CNT) begin
                  state_r  <= ST_PLAYBACK;
                  busy_r   <= 1'b1;
                  rd_ptr_r <= ZERO_PTR;
                end
`endif
              end else begin
                overflow_r <= 1'b1;
              end
            end
            K_BKSP: begin
              if (count_r != ZERO_CNT) begin
                wr_ptr_r <= wr_ptr_r - ONE_PTR;
                count_r  <= count_r - ONE_CNT;
              end
            end
            K_ESC: begin
              wr_ptr_r <= ZERO_PTR;
              count_r  <= ZERO_CNT;
            end
            K_ENTER: begin
              if (count_r != ZERO_CNT) begin
                state_r  <= ST_PLAYBACK;
                busy_r   <= 1'b1;
                rd_ptr_r <= ZERO_PTR;
              end
            end
            default: begin
            end
          endcase
        end
        ST_PLAYBACK: begin
          if (kind_s == K_ESC) begin
            state_r      <= ST_COLLECT;
            busy_r       <= 1'b0;
            char_valid_r <= 1'b0;
            wr_ptr_r     <= ZERO_PTR;
            rd_ptr_r     <= ZERO_PTR;
            count_r      <= ZERO_CNT;
          end else if (!char_valid_r) begin
            char_out_r   <= mem_r[rd_ptr_r];
            char_valid_r <= 1'b1;
          end else if (xfer_s) begin
            if (last_s) begin
              state_r      <= ST_COLLECT;
              busy_r       <= 1'b0;
              char_valid_r <= 1'b0;
              wr_ptr_r     <= ZERO_PTR;
              rd_ptr_r     <= ZERO_PTR;
              count_r      <= ZERO_CNT;
            end else begin
              rd_ptr_r   <= rd_next_s;
              char_out_r <= mem_r[rd_next_s];
            end
          end
        end
        default: begin
          state_r      <= ST_COLLECT;
          busy_r       <= 1'b0;
          char_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign char_if.char_out   = char_out_r;
  assign char_if.char_valid = char_valid_r;
  assign busy               = busy_r;
  assign buffer_count       = count_r;
  assign overflow           = overflow_r;

endmodule
